// File: rtl/rvfi_mem_responder.sv
// rvfi_mem_responder
//   Memory-side responder for a req/gnt + recv/ack bus. It holds a word-addressed
//   backing store of DEPTH_WORDS x 32 bits. Accepted requests produce one response
//   each, and responses return in order through a MAX_OUTSTANDING-deep FIFO.
//   Grants and responses can be withheld on request (stall_gnt / stall_rsp), but
//   never for longer than a bounded number of cycles.
//
// Ports
//   clock      in   1   sole clock
//   reset      in   1   asynchronous active-high reset
//   mem_req    in   1   request valid
//   mem_wen    in   1   write enable
//   mem_strb   in   4   byte write strobes
//   mem_addr   in   32  byte address
//   mem_wdata  in   32  write data
//   mem_gnt    out  1   request accepted this cycle
//   mem_recv   out  1   response valid
//   mem_ack    in   1   requester accepts response
//   mem_rdata  out  32  response read data (zero when mem_recv=0)
//   mem_error  out  1   response bus error (zero when mem_recv=0)
//   stall_gnt  in   1   request to withhold grant
//   stall_rsp  in   1   request to withhold response
module rvfi_mem_responder #(
  parameter int unsigned DEPTH_WORDS     = 256,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned MAX_REQ_STALL   = 3,
  parameter int unsigned MAX_RSP_STALL   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_gnt,
  output logic        mem_recv,
  input  logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic        mem_error,
  input  logic        stall_gnt,
  input  logic        stall_rsp
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [4:0]       GNT_LIMIT = 5'(MAX_REQ_STALL - 1);
  localparam logic [4:0]       RSP_LIMIT = 5'(MAX_RSP_STALL);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUTSTANDING - 1);

  // Backing store and response FIFO storage are not reset.
  logic [31:0]      r_mem       [DEPTH_WORDS];
  logic [31:0]      r_fifo_data [MAX_OUTSTANDING];
  logic             r_fifo_err  [MAX_OUTSTANDING];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [4:0]       r_gnt_stall_cnt;
  logic [4:0]       r_rsp_stall_cnt;
  // Set while a presented response waits for ack, so mem_recv cannot drop
  // if stall_rsp rises after the response has already been offered.
  logic             r_rsp_hold;

  logic             w_full;
  logic             w_empty;
  logic             w_gnt;
  logic             w_recv;
  logic             w_push;
  logic             w_pop;
  logic [29:0]      w_word_idx;
  logic [IDX_W-1:0] w_mem_idx;
  logic             w_addr_err;
  logic [31:0]      w_push_data;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

  // A full FIFO blocks the grant even if a pop happens in the same cycle.
  assign w_gnt  = !reset && mem_req && !w_full &&
                  (!stall_gnt || r_gnt_stall_cnt == GNT_LIMIT);
  assign w_recv = !reset && !w_empty &&
                  (!stall_rsp || r_rsp_stall_cnt == RSP_LIMIT || r_rsp_hold);

  assign w_push = w_gnt;
  assign w_pop  = w_recv && mem_ack;

  assign w_word_idx  = mem_addr[31:2];
  assign w_mem_idx   = mem_addr[IDX_W+1:2];
  assign w_addr_err  = (mem_addr[1:0] != 2'b00) || (w_word_idx >= 30'(DEPTH_WORDS));
  assign w_push_data = (mem_wen || w_addr_err) ? '0 : r_mem[w_mem_idx];

  assign mem_gnt   = w_gnt;
  assign mem_recv  = w_recv;
  assign mem_rdata = w_recv ? r_fifo_data[r_rd_ptr] : '0;
  assign mem_error = w_recv && r_fifo_err[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= w_push_data;
      r_fifo_err[r_wr_ptr]  <= w_addr_err;
      if (mem_wen && !w_addr_err) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (mem_strb[i]) begin
            r_mem[w_mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_gnt_stall_cnt <= '0;
      r_rsp_stall_cnt <= '0;
      r_rsp_hold      <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (!mem_req || w_gnt) begin
        r_gnt_stall_cnt <= '0;
      end else if (r_gnt_stall_cnt != GNT_LIMIT) begin
        r_gnt_stall_cnt <= r_gnt_stall_cnt + 1'b1;
      end

      if (w_empty || w_pop) begin
        r_rsp_stall_cnt <= '0;
      end else if (!w_recv && r_rsp_stall_cnt != RSP_LIMIT) begin
        r_rsp_stall_cnt <= r_rsp_stall_cnt + 1'b1;
      end

      r_rsp_hold <= w_recv && !mem_ack;
    end
  end

endmodule

// File: tb/tb_rvfi_mem_responder.sv
module tb_rvfi_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req;
  logic        mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_recv;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_error;
  logic        stall_gnt;
  logic        stall_rsp;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  rvfi_mem_responder #(
    .DEPTH_WORDS     (256),
    .MAX_OUTSTANDING (2),
    .MAX_REQ_STALL   (3),
    .MAX_RSP_STALL   (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_wen   (mem_wen),
    .mem_strb  (mem_strb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_recv  (mem_recv),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_error (mem_error),
    .stall_gnt (stall_gnt),
    .stall_rsp (stall_rsp)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic gnt, input logic recv,
                            input logic [31:0] rdata, input logic err);
    check({tag, ".gnt"},   {31'd0, mem_gnt},   {31'd0, gnt});
    check({tag, ".recv"},  {31'd0, mem_recv},  {31'd0, recv});
    check({tag, ".rdata"}, mem_rdata,          rdata);
    check({tag, ".error"}, {31'd0, mem_error}, {31'd0, err});
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic next_cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic req, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb);
    mem_req   = req;
    mem_wen   = wen;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_strb  = strb;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic rd(input logic [31:0] addr);
    drive(1'b1, 1'b0, addr, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    drive(1'b1, 1'b1, addr, data, strb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    mem_ack   = 1'b1;
    stall_gnt = 1'b0;
    stall_rsp = 1'b0;
    rd(32'h10);
    @(negedge clock);
    #1;
    expect_out("reset", 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();

    // Write then read, first cycle after reset release
    reset = 1'b0;
    wr(32'h10, 32'hDEADBEEF, 4'hF);
    expect_out("t1_wr", 1'b1, 1'b0, 32'h0, 1'b0);
    next_cycle(); rd(32'h10);
    expect_out("t1_rd", 1'b1, 1'b1, 32'h0, 1'b0);
    next_cycle(); idle();
    expect_out("t1_rsp", 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    next_cycle(); idle();
    expect_out("t1_idle", 1'b0, 1'b0, 32'h0, 1'b0);

    // Byte strobes
    next_cycle(); wr(32'h20, 32'h11223344, 4'hF);
    expect_out("t2_wr1", 1'b1, 1'b0, 32'h0, 1'b0);
    next_cycle(); wr(32'h20, 32'hAABBCCDD, 4'h5);
    expect_out("t2_wr2", 1'b1, 1'b1, 32'h0, 1'b0);
    next_cycle(); rd(32'h20);
    expect_out("t2_rd", 1'b1, 1'b1, 32'h0, 1'b0);
    next_cycle(); idle();
    expect_out("t2_rsp", 1'b0, 1'b1, 32'h11BB33DD, 1'b0);

    // Errors and the last valid word
    next_cycle(); rd(32'h402);
    expect_out("t3_mis", 1'b1, 1'b0, 32'h0, 1'b0);
    next_cycle(); rd(32'h400);
    expect_out("t3_oor", 1'b1, 1'b1, 32'h0, 1'b1);
    next_cycle(); wr(32'h3FC, 32'h5A5A5A5A, 4'hF);
    expect_out("t3_wlast", 1'b1, 1'b1, 32'h0, 1'b1);
    next_cycle(); rd(32'h3FC);
    expect_out("t3_rlast", 1'b1, 1'b1, 32'h0, 1'b0);
    next_cycle(); idle();
    expect_out("t3_last", 1'b0, 1'b1, 32'h5A5A5A5A, 1'b0);

    // Back-pressure: FIFO of two, no same-cycle bypass
    next_cycle(); mem_ack = 1'b0; rd(32'h10);
    expect_out("t4_r1", 1'b1, 1'b0, 32'h0, 1'b0);
    next_cycle(); rd(32'h20);
    expect_out("t4_r2", 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
    next_cycle(); rd(32'h3FC);
    expect_out("t4_full1", 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    next_cycle(); rd(32'h3FC);
    expect_out("t4_full2", 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    next_cycle(); mem_ack = 1'b1; rd(32'h3FC);
    expect_out("t4_nobyp", 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    next_cycle(); rd(32'h3FC);
    expect_out("t4_r3", 1'b1, 1'b1, 32'h11BB33DD, 1'b0);
    next_cycle(); idle();
    expect_out("t4_rsp3", 1'b0, 1'b1, 32'h5A5A5A5A, 1'b0);
    next_cycle(); idle();
    expect_out("t4_idle", 1'b0, 1'b0, 32'h0, 1'b0);

    // Stall bounds with both stalls held
    next_cycle(); stall_gnt = 1'b1; stall_rsp = 1'b1; mem_ack = 1'b0; rd(32'h10);
    expect_out("t5_g1", 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle(); rd(32'h10);
    expect_out("t5_g2", 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle(); rd(32'h10);
    expect_out("t5_g3", 1'b1, 1'b0, 32'h0, 1'b0);
    next_cycle(); idle();
    expect_out("t5_w1", 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle(); idle();
    expect_out("t5_w2", 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle(); idle();
    expect_out("t5_w3", 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle(); idle();
    expect_out("t5_forced", 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    next_cycle(); idle();
    expect_out("t5_stable", 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    next_cycle(); mem_ack = 1'b1; idle();
    expect_out("t5_ack", 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    next_cycle(); idle();
    expect_out("t5_done", 1'b0, 1'b0, 32'h0, 1'b0);

    // Reset with two responses outstanding
    next_cycle(); stall_gnt = 1'b0; stall_rsp = 1'b0; mem_ack = 1'b0; rd(32'h10);
    expect_out("t6_r1", 1'b1, 1'b0, 32'h0, 1'b0);
    next_cycle(); rd(32'h20);
    expect_out("t6_r2", 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
    next_cycle(); stall_rsp = 1'b1; idle();
    expect_out("t6_hold", 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    #2;
    reset = 1'b1;
    rd(32'h20);
    expect_out("t6_async", 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    reset = 1'b0; stall_rsp = 1'b0; mem_ack = 1'b1; idle();
    expect_out("t6_rel", 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle(); idle();
    expect_out("t6_nostale", 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle(); rd(32'h20);
    expect_out("t6_rd", 1'b1, 1'b0, 32'h0, 1'b0);
    next_cycle(); idle();
    expect_out("t6_data", 1'b0, 1'b1, 32'h11BB33DD, 1'b0);
    next_cycle(); idle();
    expect_out("t6_end", 1'b0, 1'b0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
